lif_neuron_core_pipe: RTL and testbench

//  Parametrised, pipelined LIF-only neuron core: time-multiplexes N neurons over one update datapath.

---
 rtl/neuron_pkg.sv | 49 ++++
 rtl/neuron_spk_fifo.sv | 59 +++++
 rtl/lif_neuron_core_pipe.sv | 163 ++++++++++++++++
 tb/tb_lif_neuron_core_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the LIF neuron core.
// State word layout, LSB first: v[W], leak_en, leak_str[LW], thr[W], dis.
// The field helpers take the widths as arguments, so parametrised cores get the right offsets.
// The *_BIT/*_LSB localparams give the offsets for the default 8-bit potential / 7-bit leak build.
// sat_add/sat_sub are saturating helpers on 32-bit operands; callers truncate the result.
package neuron_pkg;

  localparam int unsigned DEF_W  = 8;
  localparam int unsigned DEF_LW = 7;

  function automatic int unsigned field_leaken_bit(input int unsigned w);
    return w;
  endfunction

  function automatic int unsigned field_leak_lsb(input int unsigned w);
    return w + 1;
  endfunction

  function automatic int unsigned field_thr_lsb(input int unsigned w, input int unsigned lw);
    return w + 1 + lw;
  endfunction

  function automatic int unsigned field_dis_bit(input int unsigned w, input int unsigned lw);
    return 2 * w + 1 + lw;
  endfunction

  localparam int unsigned V_LSB      = 0;
  localparam int unsigned LEAKEN_BIT = field_leaken_bit(DEF_W);
  localparam int unsigned LEAK_LSB   = field_leak_lsb(DEF_W);
  localparam int unsigned THR_LSB    = field_thr_lsb(DEF_W, DEF_LW);
  localparam int unsigned DIS_BIT    = field_dis_bit(DEF_W, DEF_LW);

  localparam logic EVT_SYN  = 1'b0;
  localparam logic EVT_LEAK = 1'b1;

  // min(a + b, max_val); the 33-bit sum cannot wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

  // max(a - b, 0)
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/neuron_spk_fifo.sv
// Output spike FIFO: Depth entries of Width bits, power-of-two depth.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, push_data   write request and neuron address
//   pop          consumer pop; ignored when empty
//   head         head entry (0 after reset)
//   not_empty    FIFO holds at least one entry
//   count        occupancy, 0..Depth
module neuron_spk_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [Width-1:0] push_data,
  input  logic            pop,
  output logic [Width-1:0] head,
  output logic            not_empty,
  output logic [PtrW:0]   count
);

  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(Depth);

  logic [Width-1:0] store_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop & (count_q != '0);
  // A same-cycle pop frees a slot, so a push into a full FIFO is still safe then.
  assign do_push = push & ((count_q != DepthC) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) store_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        store_q[wptr_q] <= push_data;
        wptr_q          <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head      = store_q[rptr_q];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

endmodule

// File: rtl/lif_neuron_core_pipe.sv
// Pipelined LIF neuron core: N neurons time-multiplexed over one update datapath.
// S0 accepts an event and issues the state read; S1 updates v and writes back the same cycle.
// Ports:
//   CLK, RSTN_syncn                         clock, asynchronous active-low reset
//   EVT_VALID/READY/ADDR/TYPE/WEIGHT/SIGN   event input (TYPE 0 synaptic, 1 leak)
//   CFG_VALID/READY/ADDR/DATA               full state-word write, only with the pipeline empty
//   SPK_VALID/READY/ADDR                    spike FIFO output
//   MON_V                                   v of the last write-back
module lif_neuron_core_pipe
  import neuron_pkg::*;
#(
  parameter int unsigned N         = 256,
  parameter int unsigned M         = 8,
  parameter int unsigned W         = 8,
  parameter int unsigned WW        = 4,
  parameter int unsigned LW        = 7,
  parameter int unsigned SPK_DEPTH = 4,
  localparam int unsigned P        = 2 * W + LW + 2
) (
  input  logic          CLK,
  input  logic          RSTN_syncn,
  input  logic          EVT_VALID,
  output logic          EVT_READY,
  input  logic [M-1:0]  EVT_ADDR,
  input  logic          EVT_TYPE,
  input  logic [WW-1:0] EVT_WEIGHT,
  input  logic          EVT_SIGN,
  input  logic          CFG_VALID,
  output logic          CFG_READY,
  input  logic [M-1:0]  CFG_ADDR,
  input  logic [P-1:0]  CFG_DATA,
  output logic          SPK_VALID,
  input  logic          SPK_READY,
  output logic [M-1:0]  SPK_ADDR,
  output logic [W-1:0]  MON_V
);

  localparam int unsigned LeakEnBit = field_leaken_bit(W);
  localparam int unsigned LeakLsb   = field_leak_lsb(W);
  localparam int unsigned ThrLsb    = field_thr_lsb(W, LW);
  localparam int unsigned DisBit    = field_dis_bit(W, LW);
  localparam int unsigned CntW      = $clog2(SPK_DEPTH) + 1;
  localparam logic [31:0] VMax      = (32'd1 << W) - 32'd1;

  // Handshakes
  logic            evt_fire, cfg_fire;
  logic [CntW-1:0] spk_count, free_slots;

  // S1 registers
  logic            s1_valid_q;
  logic [M-1:0]    s1_addr_q;
  logic            s1_type_q;
  logic [WW-1:0]   s1_weight_q;
  logic            s1_sign_q;
  logic            fwd_hit_q;
  logic [P-1:0]    fwd_word_q;
  logic [W-1:0]    mon_v_q;

  // State memory
  logic [P-1:0]    mem [N];
  logic [P-1:0]    rd_q;
  logic            mem_we;
  logic [M-1:0]    mem_waddr;
  logic [P-1:0]    mem_wdata;

  // S1 datapath
  logic [P-1:0]    s1_word, wb_word;
  logic [W-1:0]    v, thr, v_upd, v_wb, v_add, v_sub, v_leak;
  logic [LW-1:0]   leak_str;
  logic            leak_en, dis, spike, hazard;

  assign free_slots = CntW'(SPK_DEPTH) - spk_count;

  // Admit an event only if both the S1 spike and this event's spike are guaranteed a slot.
  assign EVT_READY = RSTN_syncn & ~CFG_VALID & (free_slots > {{(CntW-1){1'b0}}, s1_valid_q});
  assign CFG_READY = RSTN_syncn & ~s1_valid_q;
  assign evt_fire  = EVT_VALID & EVT_READY;
  assign cfg_fire  = CFG_VALID & CFG_READY;

  assign hazard = s1_valid_q & (s1_addr_q == EVT_ADDR);

  always_ff @(posedge CLK or negedge RSTN_syncn) begin
    if (!RSTN_syncn) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_type_q   <= EVT_SYN;
      s1_weight_q <= '0;
      s1_sign_q   <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_word_q  <= '0;
      mon_v_q     <= '0;
    end else begin
      s1_valid_q <= evt_fire;
      if (evt_fire) begin
        s1_addr_q   <= EVT_ADDR;
        s1_type_q   <= EVT_TYPE;
        s1_weight_q <= EVT_WEIGHT;
        s1_sign_q   <= EVT_SIGN;
        // The memory read of this cycle returns the pre-write-back word; take S1's result.
        fwd_hit_q   <= hazard;
        fwd_word_q  <= wb_word;
      end
      if (s1_valid_q) mon_v_q <= v_wb;
    end
  end

  // Behavioural synchronous-read RAM; a CFG write never coincides with a write-back.
  assign mem_we    = s1_valid_q | cfg_fire;
  assign mem_waddr = cfg_fire ? CFG_ADDR : s1_addr_q;
  assign mem_wdata = cfg_fire ? CFG_DATA : wb_word;

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (evt_fire) rd_q <= mem[EVT_ADDR];
  end

  assign s1_word  = fwd_hit_q ? fwd_word_q : rd_q;
  assign v        = s1_word[V_LSB +: W];
  assign leak_en  = s1_word[LeakEnBit];
  assign leak_str = s1_word[LeakLsb +: LW];
  assign thr      = s1_word[ThrLsb +: W];
  assign dis      = s1_word[DisBit];

  assign v_add  = W'(sat_add(32'(v), 32'(s1_weight_q), VMax));
  assign v_sub  = W'(sat_sub(32'(v), 32'(s1_weight_q)));
  assign v_leak = W'(sat_sub(32'(v), 32'(leak_str)));

  always_comb begin
    v_upd = v;
    if (s1_type_q == EVT_SYN) begin
      v_upd = s1_sign_q ? v_sub : v_add;
    end else if (leak_en) begin
      v_upd = v_leak;
    end
    spike = s1_valid_q & ~dis & (s1_type_q == EVT_SYN) & ~s1_sign_q & (v_upd >= thr);
    if (dis) begin
      v_wb = v;
    end else if (spike) begin
      v_wb = '0;
    end else begin
      v_wb = v_upd;
    end
    wb_word = s1_word;
    wb_word[V_LSB +: W] = v_wb;
  end

  neuron_spk_fifo #(
    .Depth (SPK_DEPTH),
    .Width (M)
  ) u_spk_fifo (
    .clk       (CLK),
    .rst_n     (RSTN_syncn),
    .push      (spike),
    .push_data (s1_addr_q),
    .pop       (SPK_READY),
    .head      (SPK_ADDR),
    .not_empty (SPK_VALID),
    .count     (spk_count)
  );

  assign MON_V = mon_v_q;

endmodule

// File: tb/tb_lif_neuron_core_pipe.sv
module tb_lif_neuron_core_pipe;

  localparam int unsigned N = 256, M = 8, W = 8, WW = 4, LW = 7, SPK_DEPTH = 4;
  localparam int unsigned P = 2 * W + LW + 2;
  localparam int VMAX = (1 << W) - 1;

  logic          CLK = 1'b0;
  logic          RSTN_syncn = 1'b0;
  logic          EVT_VALID = 1'b0;
  logic          EVT_READY;
  logic [M-1:0]  EVT_ADDR = '0;
  logic          EVT_TYPE = 1'b0;
  logic [WW-1:0] EVT_WEIGHT = '0;
  logic          EVT_SIGN = 1'b0;
  logic          CFG_VALID = 1'b0;
  logic          CFG_READY;
  logic [M-1:0]  CFG_ADDR = '0;
  logic [P-1:0]  CFG_DATA = '0;
  logic          SPK_VALID;
  logic          SPK_READY = 1'b1;
  logic [M-1:0]  SPK_ADDR;
  logic [W-1:0]  MON_V;

  always #5 CLK = ~CLK;

  lif_neuron_core_pipe #(
    .N(N), .M(M), .W(W), .WW(WW), .LW(LW), .SPK_DEPTH(SPK_DEPTH)
  ) dut (
    .CLK        (CLK),
    .RSTN_syncn (RSTN_syncn),
    .EVT_VALID  (EVT_VALID),
    .EVT_READY  (EVT_READY),
    .EVT_ADDR   (EVT_ADDR),
    .EVT_TYPE   (EVT_TYPE),
    .EVT_WEIGHT (EVT_WEIGHT),
    .EVT_SIGN   (EVT_SIGN),
    .CFG_VALID  (CFG_VALID),
    .CFG_READY  (CFG_READY),
    .CFG_ADDR   (CFG_ADDR),
    .CFG_DATA   (CFG_DATA),
    .SPK_VALID  (SPK_VALID),
    .SPK_READY  (SPK_READY),
    .SPK_ADDR   (SPK_ADDR),
    .MON_V      (MON_V)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model of the neuron state, serial semantics.
  logic [P-1:0] model_mem [N];
  logic [M-1:0] spk_q [$];

  function automatic logic [P-1:0] mk_word(input bit dis, input int thr, input int lstr,
                                           input bit len, input int v);
    logic [P-1:0] w;
    w = '0;
    w[P-1]          = dis;
    w[W+1+LW +: W]  = W'(thr);
    w[W+1 +: LW]    = LW'(lstr);
    w[W]            = len;
    w[W-1:0]        = W'(v);
    return w;
  endfunction

  task automatic model_eval(input logic [P-1:0] word, input bit typ, input int wt,
                            input bit sgn, output logic [P-1:0] nword, output int vout,
                            output bit spk);
    int v, thr, ls;
    bit len, dis;
    v    = int'(word[W-1:0]);
    len  = word[W];
    ls   = int'(word[W+1 +: LW]);
    thr  = int'(word[W+1+LW +: W]);
    dis  = word[P-1];
    spk  = 1'b0;
    vout = v;
    if (!dis) begin
      if (typ == 1'b0) begin
        if (sgn) begin
          vout = (v - wt < 0) ? 0 : v - wt;
        end else begin
          vout = (v + wt > VMAX) ? VMAX : v + wt;
          if (vout >= thr) begin
            spk  = 1'b1;
            vout = 0;
          end
        end
      end else if (len) begin
        vout = (v - ls < 0) ? 0 : v - ls;
      end
    end
    nword = word;
    nword[W-1:0] = W'(vout);
  endtask

  // Monitor: accept seen at negedge n, modelled at n+1, MON_V checked at n+2.
  bit           p1 = 1'b0, p2 = 1'b0;
  logic [M-1:0] p1_addr;
  bit           p1_type, p1_sign;
  int           p1_wt, p2_v;

  always @(negedge CLK) begin
    logic [P-1:0] nw;
    int vo;
    bit sp;
    if (!RSTN_syncn) begin
      p1 = 1'b0;
      p2 = 1'b0;
    end else begin
      if (p2) check_eq("mon_v", 32'(MON_V), 32'(p2_v));
      p2 = 1'b0;
      if (p1) begin
        model_eval(model_mem[p1_addr], p1_type, p1_wt, p1_sign, nw, vo, sp);
        model_mem[p1_addr] = nw;
        p2   = 1'b1;
        p2_v = vo;
        if (sp) spk_q.push_back(p1_addr);
      end
      p1      = EVT_VALID && EVT_READY;
      p1_addr = EVT_ADDR;
      p1_type = EVT_TYPE;
      p1_wt   = int'(EVT_WEIGHT);
      p1_sign = EVT_SIGN;
      if (SPK_VALID && SPK_READY) begin
        if (spk_q.size() == 0) check_eq("spk_unexpected", 32'(SPK_VALID), 32'd0);
        else check_eq("spk_addr", 32'(SPK_ADDR), 32'(spk_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [P-1:0] word);
    int t;
    t = 0;
    CFG_VALID = 1'b1;
    CFG_ADDR  = M'(addr);
    CFG_DATA  = word;
    @(negedge CLK);
    while (!CFG_READY && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!CFG_READY) begin
      check_eq("cfg_timeout", 32'(CFG_READY), 32'd1);
      CFG_VALID = 1'b0;
    end else begin
      @(posedge CLK);
      model_mem[addr] = word;
      #1 CFG_VALID = 1'b0;
    end
  endtask

  // Leaves EVT_VALID high so consecutive calls issue back-to-back events.
  task automatic send_evt(input int addr, input bit typ, input int wt, input bit sgn);
    int t;
    t = 0;
    EVT_VALID  = 1'b1;
    EVT_ADDR   = M'(addr);
    EVT_TYPE   = typ;
    EVT_WEIGHT = WW'(wt);
    EVT_SIGN   = sgn;
    @(negedge CLK);
    while (!EVT_READY && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!EVT_READY) begin
      check_eq("evt_timeout", 32'(EVT_READY), 32'd1);
      EVT_VALID = 1'b0;
    end else begin
      tick();
    end
  endtask

  task automatic drain_spikes();
    int t;
    t = 0;
    while (spk_q.size() != 0 && t < 40) begin
      tick();
      t++;
    end
    tick();
    tick();
    check_eq("spk_q_empty", 32'(spk_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [M-1:0] a;
    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_evt_ready", 32'(EVT_READY), 32'd0);
    check_eq("rst_cfg_ready", 32'(CFG_READY), 32'd0);
    check_eq("rst_spk_valid", 32'(SPK_VALID), 32'd0);
    check_eq("rst_spk_addr", 32'(SPK_ADDR), 32'd0);
    check_eq("rst_mon_v", 32'(MON_V), 32'd0);
    @(posedge CLK);
    #1 RSTN_syncn = 1'b1;
    @(negedge CLK);
    check_eq("evt_ready_post_rst", 32'(EVT_READY), 32'd1);
    tick();

    // 1: three excitatory w=4 events, third one spikes
    cfg_write(5, mk_word(0, 10, 0, 0, 0));
    send_evt(5, 0, 4, 0);
    send_evt(5, 0, 4, 0);
    send_evt(5, 0, 4, 0);
    EVT_VALID = 1'b0;
    check_eq("t1_spk_not_yet", 32'(SPK_VALID), 32'd0);
    tick();
    check_eq("t1_spk_valid_lat2", 32'(SPK_VALID), 32'd1);
    check_eq("t1_spk_addr", 32'(SPK_ADDR), 32'd5);
    drain_spikes();
    check_eq("t1_v_after_spike", 32'(MON_V), 32'd0);

    // 2: leak floor, leak partial, inhibitory floor, excitatory saturation
    cfg_write(1, mk_word(0, 200, 5, 1, 3));
    send_evt(1, 1, 0, 0);
    EVT_VALID = 1'b0;
    tick(); tick();
    check_eq("t2_leak_floor", 32'(MON_V), 32'd0);
    cfg_write(4, mk_word(0, 200, 5, 1, 9));
    send_evt(4, 1, 15, 1);
    EVT_VALID = 1'b0;
    tick(); tick();
    check_eq("t2_leak_sub", 32'(MON_V), 32'd4);
    cfg_write(2, mk_word(0, 255, 0, 0, 2));
    send_evt(2, 0, 15, 1);
    EVT_VALID = 1'b0;
    tick(); tick();
    check_eq("t2_inhib_floor", 32'(MON_V), 32'd0);
    check_eq("t2_inhib_no_spk", 32'(SPK_VALID), 32'd0);
    cfg_write(3, mk_word(0, 255, 0, 0, 250));
    send_evt(3, 0, 15, 0);
    EVT_VALID = 1'b0;
    tick();
    check_eq("t2_sat_spk_valid", 32'(SPK_VALID), 32'd1);
    check_eq("t2_sat_spk_addr", 32'(SPK_ADDR), 32'd3);
    drain_spikes();

    // 3: eight back-to-back events to one neuron
    cfg_write(7, mk_word(0, 255, 0, 0, 0));
    for (int i = 0; i < 8; i++) send_evt(7, 0, 1, 0);
    EVT_VALID = 1'b0;
    tick(); tick();
    check_eq("t3_fwd_v8", 32'(MON_V), 32'd8);

    // 4: FIFO fills to depth with SPK_READY low, then drains in order
    for (int i = 12; i < 22; i++) cfg_write(i, mk_word(0, 0, 0, 0, 0));
    SPK_READY  = 1'b0;
    acc        = 0;
    a          = M'(12);
    EVT_VALID  = 1'b1;
    EVT_TYPE   = 1'b0;
    EVT_WEIGHT = WW'(1);
    EVT_SIGN   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      EVT_ADDR = a;
      @(negedge CLK);
      if (EVT_READY) acc++;
      tick();
      a = a + 1'b1;
    end
    EVT_VALID = 1'b0;
    check_eq("t4_accepted", 32'(acc), 32'd4);
    check_eq("t4_queued", 32'(spk_q.size()), 32'd4);
    @(negedge CLK);
    check_eq("t4_evt_ready_low", 32'(EVT_READY), 32'd0);
    check_eq("t4_spk_valid", 32'(SPK_VALID), 32'd1);
    check_eq("t4_head", 32'(SPK_ADDR), 32'd12);
    tick();
    SPK_READY = 1'b1;
    drain_spikes();
    check_eq("t4_drained", 32'(SPK_VALID), 32'd0);

    // 5: CFG waits for S1 to drain; disabled neuron is frozen
    cfg_write(30, mk_word(0, 255, 0, 0, 0));
    send_evt(30, 0, 1, 0);
    EVT_VALID = 1'b0;
    CFG_VALID = 1'b1;
    CFG_ADDR  = M'(31);
    CFG_DATA  = mk_word(1, 10, 0, 0, 7);
    @(negedge CLK);
    check_eq("t5_cfg_wait", 32'(CFG_READY), 32'd0);
    check_eq("t5_evt_blocked", 32'(EVT_READY), 32'd0);
    tick();
    @(negedge CLK);
    check_eq("t5_cfg_ready", 32'(CFG_READY), 32'd1);
    check_eq("t5_evt_blocked2", 32'(EVT_READY), 32'd0);
    @(posedge CLK);
    model_mem[31] = mk_word(1, 10, 0, 0, 7);
    #1 CFG_VALID = 1'b0;
    send_evt(31, 0, 15, 0);
    EVT_VALID = 1'b0;
    tick(); tick();
    check_eq("t5_dis_v", 32'(MON_V), 32'd7);
    check_eq("t5_dis_no_spk", 32'(SPK_VALID), 32'd0);

    // 6: reset while S1 is valid drops the write-back
    cfg_write(9, mk_word(0, 255, 0, 0, 20));
    send_evt(9, 0, 5, 0);
    EVT_VALID  = 1'b0;
    RSTN_syncn = 1'b0;
    @(negedge CLK);
    check_eq("t6_rst_spk_valid", 32'(SPK_VALID), 32'd0);
    check_eq("t6_rst_evt_ready", 32'(EVT_READY), 32'd0);
    check_eq("t6_rst_cfg_ready", 32'(CFG_READY), 32'd0);
    check_eq("t6_rst_mon_v", 32'(MON_V), 32'd0);
    @(posedge CLK);
    #1 RSTN_syncn = 1'b1;
    @(negedge CLK);
    check_eq("t6_evt_ready_release", 32'(EVT_READY), 32'd1);
    tick();
    send_evt(9, 1, 0, 0);
    EVT_VALID = 1'b0;
    tick(); tick();
    check_eq("t6_word_kept", 32'(MON_V), 32'd20);
    check_eq("t6_no_spk", 32'(SPK_VALID), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
